// File: rtl/bcd_entry_ctrl_if.sv
// Bundle between the KEY/SW front end and bcd_entry_ctrl.
// The controller takes the slave modport; whatever drives the keys takes master.
interface bcd_entry_ctrl_if #(
    parameter int NUM_DIGITS = 3
);
    localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    enter;
    logic                    cancel;
    logic [3:0]              digit_in;
    logic                    sign_in;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    value_neg;
    logic                    valid;
    logic                    commit;
    logic                    err;
    logic [PW-1:0]           cur_pos;
    logic                    entering;
    logic                    blink;
    logic [4*NUM_DIGITS-1:0] disp;
    logic                    disp_neg;

    modport slave (
        input  enter, cancel, digit_in, sign_in,
        output value, value_neg, valid, commit, err, cur_pos, entering,
               blink, disp, disp_neg
    );

    modport master (
        output enter, cancel, digit_in, sign_in,
        input  value, value_neg, valid, commit, err, cur_pos, entering,
               blink, disp, disp_neg
    );
endinterface

// File: rtl/bcd_entry_ctrl.sv
// Signed N-digit BCD entry controller: collects digits ones-first on enter presses,
// commits number and sign atomically, and produces blinking seven-segment codes.
module bcd_entry_ctrl #(
    parameter int         NUM_DIGITS = 3,
    parameter int         BLINK_DIV  = 25_000_000,
    parameter logic [3:0] OFF_CODE   = 4'hF,
    parameter bit         LZ_BLANK   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    bcd_entry_ctrl_if.slave bus
);
    localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] LAST_POS = PW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_DIV - 1);

    typedef enum logic {ST_ENTRY, ST_HOLD} state_t;

    state_t                     r_state, w_stateNext;
    logic                       r_enterQ;
    logic [PW-1:0]              r_curPos, w_curPosNext;
    logic [NUM_DIGITS-1:0][3:0] r_shadow, w_shadowNext;
    logic [NUM_DIGITS-1:0][3:0] r_value, w_valueNext;
    logic                       r_valueNeg, w_valueNegNext;
    logic                       r_valid, w_validNext;
    logic                       r_commit, w_commitNext;
    logic                       r_err, w_errNext;
    logic [CW-1:0]              r_blinkCnt, w_blinkCntNext;
    logic                       r_blink, w_blinkNext;
    logic [NUM_DIGITS-1:0][3:0] r_disp, w_dispNext;
    logic                       r_dispNeg, w_dispNegNext;
    logic                       w_press;
    logic                       w_lead;

    assign w_press = bus.enter & ~r_enterQ;

    always_comb begin
        w_blinkCntNext = r_blinkCnt + 1'b1;
        w_blinkNext    = r_blink;
        if (r_blinkCnt == BLINK_TC) begin
            w_blinkCntNext = '0;
            w_blinkNext    = ~r_blink;
        end
    end

    // The top shadow slot is never written, so a commit can copy the whole shadow
    // and overwrite only the most-significant digit with the live input.
    always_comb begin
        w_stateNext    = r_state;
        w_curPosNext   = r_curPos;
        w_shadowNext   = r_shadow;
        w_valueNext    = r_value;
        w_valueNegNext = r_valueNeg;
        w_validNext    = r_valid;
        w_commitNext   = 1'b0;
        w_errNext      = 1'b0;
        case (r_state)
            ST_ENTRY: begin
                if (bus.cancel) begin
                    w_shadowNext = '0;
                    w_curPosNext = '0;
                    w_stateNext  = r_valid ? ST_HOLD : ST_ENTRY;
                end else if (w_press) begin
                    if (bus.digit_in > 4'd9) begin
                        w_errNext = 1'b1;
                    end else if (r_curPos == LAST_POS) begin
                        w_valueNext                 = r_shadow;
                        w_valueNext[NUM_DIGITS-1]   = bus.digit_in;
                        w_valueNegNext              = bus.sign_in;
                        w_validNext                 = 1'b1;
                        w_commitNext                = 1'b1;
                        w_curPosNext                = '0;
                        w_shadowNext                = '0;
                        w_stateNext                 = ST_HOLD;
                    end else begin
                        w_shadowNext[r_curPos] = bus.digit_in;
                        w_curPosNext           = r_curPos + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_press) begin
                    w_stateNext  = ST_ENTRY;
                    w_curPosNext = '0;
                end
            end
            default: w_stateNext = ST_ENTRY;
        endcase
    end

    // Display is built from next-state values so it lines up with the other outputs.
    always_comb begin
        w_dispNext    = '0;
        w_dispNegNext = 1'b0;
        w_lead        = LZ_BLANK;
        if (w_stateNext == ST_ENTRY) begin
            w_dispNegNext = bus.sign_in;
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if (j < int'(w_curPosNext)) begin
                    w_dispNext[j] = w_shadowNext[j];
                end else if (j == int'(w_curPosNext)) begin
                    w_dispNext[j] = w_blinkNext ? bus.digit_in : OFF_CODE;
                end else begin
                    w_dispNext[j] = OFF_CODE;
                end
            end
        end else begin
            w_dispNegNext = w_valueNegNext;
            for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
                if (w_lead && (j != 0) && (w_valueNext[j] == 4'd0)) begin
                    w_dispNext[j] = OFF_CODE;
                end else begin
                    w_dispNext[j] = w_valueNext[j];
                    w_lead        = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ENTRY;
            r_enterQ   <= 1'b1;
            r_curPos   <= '0;
            r_shadow   <= '0;
            r_value    <= '0;
            r_valueNeg <= 1'b0;
            r_valid    <= 1'b0;
            r_commit   <= 1'b0;
            r_err      <= 1'b0;
            r_blinkCnt <= '0;
            r_blink    <= 1'b1;
            r_disp     <= {NUM_DIGITS{OFF_CODE}};
            r_dispNeg  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_enterQ   <= bus.enter;
            r_curPos   <= w_curPosNext;
            r_shadow   <= w_shadowNext;
            r_value    <= w_valueNext;
            r_valueNeg <= w_valueNegNext;
            r_valid    <= w_validNext;
            r_commit   <= w_commitNext;
            r_err      <= w_errNext;
            r_blinkCnt <= w_blinkCntNext;
            r_blink    <= w_blinkNext;
            r_disp     <= w_dispNext;
            r_dispNeg  <= w_dispNegNext;
        end
    end

    assign bus.value     = r_value;
    assign bus.value_neg = r_valueNeg;
    assign bus.valid     = r_valid;
    assign bus.commit    = r_commit;
    assign bus.err       = r_err;
    assign bus.cur_pos   = r_curPos;
    assign bus.entering  = (r_state == ST_ENTRY);
    assign bus.blink     = r_blink;
    assign bus.disp      = r_disp;
    assign bus.disp_neg  = r_dispNeg;
endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Directed bench for bcd_entry_ctrl: dutA plain display, dutB with leading-zero
// blanking, both driven identically; commits are checked against a scoreboard queue.
module tb_bcd_entry_ctrl;
    typedef struct {
        logic [11:0] value;
        logic        neg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   nEdges      = 0;
    int   commitCount = 0;
    int   cc;
    exp_t expQ[$];

    bcd_entry_ctrl_if #(.NUM_DIGITS(3)) ifA ();
    bcd_entry_ctrl_if #(.NUM_DIGITS(3)) ifB ();

    bcd_entry_ctrl #(.NUM_DIGITS(3), .BLINK_DIV(4), .OFF_CODE(4'hF), .LZ_BLANK(1'b0)) dutA (
        .clk(clk), .rst(rst), .bus(ifA)
    );
    bcd_entry_ctrl #(.NUM_DIGITS(3), .BLINK_DIV(4), .OFF_CODE(4'hF), .LZ_BLANK(1'b1)) dutB (
        .clk(clk), .rst(rst), .bus(ifB)
    );

    always #5 clk = ~clk;

    // Independent blink reference: count of non-reset clock edges.
    always @(posedge clk) begin
        if (rst) nEdges <= 0;
        else     nEdges <= nEdges + 1;
        if (ifA.commit === 1'b1) commitCount <= commitCount + 1;
    end

    function automatic logic expBlink();
        return ((nEdges / 4) % 2) == 0;
    endfunction

    function automatic logic [11:0] expEntry(input int pos, input logic [11:0] sh,
                                             input logic [3:0] dig, input logic bl);
        logic [11:0] r;
        r = '0;
        for (int j = 0; j < 3; j++) begin
            if (j < pos)       r[4*j +: 4] = sh[4*j +: 4];
            else if (j == pos) r[4*j +: 4] = bl ? dig : 4'hF;
            else               r[4*j +: 4] = 4'hF;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic can, input logic [3:0] dig, input logic sgn);
        ifA.enter = en; ifA.cancel = can; ifA.digit_in = dig; ifA.sign_in = sgn;
        ifB.enter = en; ifB.cancel = can; ifB.digit_in = dig; ifB.sign_in = sgn;
    endtask

    task automatic pressKey(input logic [3:0] dig, input logic sgn);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, dig, sgn);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, dig, sgn);
    endtask

    task automatic cancelKey(input logic [3:0] dig, input logic sgn);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, dig, sgn);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, dig, sgn);
    endtask

    // Bounded wait for the commit pulse, then pop and compare the scoreboard head.
    task automatic waitCommit(input logic [11:0] expDispB);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ifA.commit === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("commit_seen", 32'(seen), 32'd1);
        checkOutput("queue_nonempty", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("commit_value", 32'(ifA.value), 32'(e.value));
            checkOutput("commit_neg", 32'(ifA.value_neg), 32'(e.neg));
            checkOutput("hold_dispA", 32'(ifA.disp), 32'(e.value));
            checkOutput("hold_dispB", 32'(ifB.disp), 32'(expDispB));
        end
        checkOutput("commit_valid", 32'(ifA.valid), 32'd1);
        checkOutput("commit_hold", 32'(ifA.entering), 32'd0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_value", 32'(ifA.value), 32'h000);
        checkOutput("rst_valid", 32'(ifA.valid), 32'd0);
        checkOutput("rst_commit", 32'(ifA.commit), 32'd0);
        checkOutput("rst_err", 32'(ifA.err), 32'd0);
        checkOutput("rst_curpos", 32'(ifA.cur_pos), 32'd0);
        checkOutput("rst_entering", 32'(ifA.entering), 32'd1);
        checkOutput("rst_blink", 32'(ifA.blink), 32'(expBlink()));
        checkOutput("rst_disp", 32'(ifA.disp), 32'(expEntry(0, 12'h000, 4'd0, expBlink())));

        // Enter 5,2,7 negative -> 725
        pressKey(4'd5, 1'b1);
        checkOutput("t1_pos1", 32'(ifA.cur_pos), 32'd1);
        checkOutput("t1_nocommit", 32'(ifA.commit), 32'd0);
        checkOutput("t1_disp1", 32'(ifA.disp), 32'(expEntry(1, 12'h005, 4'd5, expBlink())));
        pressKey(4'd2, 1'b1);
        checkOutput("t1_pos2", 32'(ifA.cur_pos), 32'd2);
        expQ.push_back('{value: 12'h725, neg: 1'b1});
        pressKey(4'd7, 1'b1);
        waitCommit(12'h725);
        checkOutput("t1_dispneg", 32'(ifA.disp_neg), 32'd1);
        @(negedge clk);
        checkOutput("t1_commit_once", 32'(ifA.commit), 32'd0);

        // HOLD -> ENTRY, digit 3, rejected C, then cancel back to HOLD
        pressKey(4'd9, 1'b0);
        checkOutput("t3_entry", 32'(ifA.entering), 32'd1);
        checkOutput("t3_pos0", 32'(ifA.cur_pos), 32'd0);
        checkOutput("t3_noerr", 32'(ifA.err), 32'd0);
        pressKey(4'd3, 1'b0);
        checkOutput("t3_pos1", 32'(ifA.cur_pos), 32'd1);
        pressKey(4'hC, 1'b0);
        checkOutput("t2_err", 32'(ifA.err), 32'd1);
        checkOutput("t2_pos", 32'(ifA.cur_pos), 32'd1);
        @(negedge clk);
        checkOutput("t2_err_once", 32'(ifA.err), 32'd0);
        checkOutput("t2_shadow", 32'(ifA.disp), 32'(expEntry(1, 12'h003, 4'hC, expBlink())));
        cc = commitCount;
        cancelKey(4'hC, 1'b0);
        checkOutput("t3_hold", 32'(ifA.entering), 32'd0);
        checkOutput("t3_pos_clr", 32'(ifA.cur_pos), 32'd0);
        checkOutput("t3_value", 32'(ifA.value), 32'h725);
        checkOutput("t3_nocommit", 32'(commitCount), 32'(cc));

        // enter and cancel together: cancel wins
        pressKey(4'd0, 1'b0);
        pressKey(4'd6, 1'b0);
        checkOutput("t4_pos1", 32'(ifA.cur_pos), 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 4'd2, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'd2, 1'b0);
        checkOutput("t4_pos0", 32'(ifA.cur_pos), 32'd0);
        checkOutput("t4_hold", 32'(ifA.entering), 32'd0);
        checkOutput("t4_value", 32'(ifA.value), 32'h725);
        checkOutput("t4_nocommit", 32'(commitCount), 32'(cc));
        pressKey(4'd2, 1'b0);
        checkOutput("t4_shadow_clr", 32'(ifA.disp), 32'(expEntry(0, 12'h000, 4'd2, expBlink())));

        // Blink and display preview with a non-BCD code on the live digit
        pressKey(4'd8, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'hB, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t5_blink", 32'(ifA.blink), 32'(expBlink()));
            checkOutput("t5_disp", 32'(ifA.disp), 32'(expEntry(1, 12'h008, 4'hB, expBlink())));
            checkOutput("t5_dispneg", 32'(ifA.disp_neg), 32'd1);
        end

        // Leading-zero blanking on dutB
        cancelKey(4'd0, 1'b0);
        pressKey(4'd0, 1'b0);
        pressKey(4'd0, 1'b0);
        pressKey(4'd0, 1'b0);
        expQ.push_back('{value: 12'h000, neg: 1'b0});
        pressKey(4'd0, 1'b0);
        waitCommit(12'hFF0);
        pressKey(4'd1, 1'b0);
        pressKey(4'd5, 1'b0);
        pressKey(4'd0, 1'b0);
        expQ.push_back('{value: 12'h005, neg: 1'b0});
        pressKey(4'd0, 1'b0);
        waitCommit(12'hFF5);
        pressKey(4'd1, 1'b0);
        pressKey(4'd0, 1'b0);
        pressKey(4'd5, 1'b0);
        expQ.push_back('{value: 12'h050, neg: 1'b0});
        pressKey(4'd0, 1'b0);
        waitCommit(12'hF50);

        // Enter held through reset must not register
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 4'd4, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("r_value", 32'(ifA.value), 32'h000);
        checkOutput("r_valid", 32'(ifA.valid), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("r_held_pos", 32'(ifA.cur_pos), 32'd0);
        checkOutput("r_held_entry", 32'(ifA.entering), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'd4, 1'b0);
        pressKey(4'd4, 1'b0);
        checkOutput("r_repress_pos", 32'(ifA.cur_pos), 32'd1);

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
